mem_arbiter: RTL and testbench

Two-port arbiter and burst sequencer that shares the single unified `memory` port between the instruction-fetch requester (I) and the load/store requester (D) of the MIPS pipeline. It selects one requester at a time, drives the memory's address, data, access size, read/write and enable lines for the whole burst (1, 4, 8 or 16 words), and forwards read data and completion back to the granted requester.

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch / load-store) arbiter and burst sequencer for
//               a single unified memory port. Bursts of 1, 4, 8 or 16 words.
//               Optional macro MEM_ARB_FIXED_PRIO_EN selects fixed priority
//               (D beats I) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  // fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  // load/store requester
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  // memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_own_d;     // 1 = current burst belongs to D
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_rw;
  logic [3:0]        r_beat;
  logic              r_i_gnt;
  logic              r_d_gnt;
  logic              r_en;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic              r_i_done;
  logic              r_d_done;

  logic              w_pick_d;
  logic [3:0]        w_last_cnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_wr_active;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // D always wins a tie; no fairness state is kept.
  assign w_pick_d = d_req;
`else
  logic r_last_d;  // 1 = D was granted last, 0 = I was granted last

  // Round-robin: on a tie the side that was not granted last wins.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  // Last-granted pointer, updated at each grant decision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == ST_IDLE && (i_req || d_req)) begin
      r_last_d <= w_pick_d;
    end
  end
`endif

  assign w_sel_addr = w_pick_d ? d_addr : i_addr;

  // Final beat index for the latched burst size.
  always_comb begin
    w_last_cnt = 4'd0;
    case (r_size)
      2'b00:   w_last_cnt = 4'd0;
      2'b01:   w_last_cnt = 4'd3;
      2'b10:   w_last_cnt = 4'd7;
      default: w_last_cnt = 4'd15;
    endcase
  end

  // Burst sequencer: grant latch, beat/address stepping and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_own_d    <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_rw       <= 1'b0;
      r_beat     <= 4'd0;
      r_i_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_en       <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle.
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            r_state <= ST_ACCESS;
            r_own_d <= w_pick_d;
            r_addr  <= {w_sel_addr[ADDR_W-1:2], 2'b00};
            r_size  <= w_pick_d ? d_size : i_size;
            r_rw    <= w_pick_d ? d_rw : 1'b1;   // fetch is always a read
            r_beat  <= 4'd0;
            r_i_gnt <= ~w_pick_d;
            r_d_gnt <= w_pick_d;
            r_en    <= 1'b1;
          end
        end
        ST_ACCESS: begin
          // A stalled beat holds address and counter.
          if (!mem_busy) begin
            r_addr     <= r_addr + ADDR_W'(4);
            r_beat     <= r_beat + 4'd1;
            r_i_rvalid <= ~r_own_d;
            r_d_rvalid <= r_own_d & r_rw;
            if (r_beat == w_last_cnt) begin
              r_state  <= ST_DRAIN;
              r_en     <= 1'b0;
              r_i_done <= ~r_own_d;
              r_d_done <= r_own_d;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
          r_i_gnt <= 1'b0;
          r_d_gnt <= 1'b0;
          r_beat  <= 4'd0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data only reaches memory while D owns an active write burst.
  assign w_wr_active = r_en & r_own_d & ~r_rw;

  assign i_gnt           = r_i_gnt;
  assign d_gnt           = r_d_gnt;
  assign i_rvalid        = r_i_rvalid;
  assign d_rvalid        = r_d_rvalid;
  assign i_done          = r_i_done;
  assign d_done          = r_d_done;
  assign i_rdata         = r_i_rvalid ? mem_data_out : '0;
  assign d_rdata         = r_d_rvalid ? mem_data_out : '0;
  assign d_wready        = (r_state == ST_ACCESS) & ~mem_busy & r_own_d & ~r_rw;
  assign mem_address     = r_addr;
  assign mem_data_in     = w_wr_active ? d_wdata : '0;
  assign mem_access_size = r_size;
  assign mem_rw          = r_rw;
  assign mem_enable      = r_en;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        i_gnt, i_rvalid, i_done;
  logic [31:0] i_rdata;
  logic        d_req, d_rw;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_wready, d_gnt, d_rvalid, d_done;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable, mem_busy;
  logic [31:0] mem_data_out;

  int n_checks = 0;
  int n_err    = 0;
  int w;
  int nrv;
  int b;
  logic        exp_d;
  logic [31:0] ea;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_wready(d_wready), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  // Memory content: one fixed word at the boot address, inverted address elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h8002_0000) ? 32'h27BD_FFE8 : ~a;
  endfunction

  // Synchronous-read memory model: data appears the cycle after an accepted read beat.
  always @(posedge clock) begin
    if (mem_enable && !mem_busy && mem_rw) mem_data_out <= mem_f(mem_address);
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_req = 1'b0; i_addr = '0; i_size = 2'b00;
    d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_size = 2'b00;
    d_wdata = 32'hDEAD_BEEF; mem_busy = 1'b0; mem_data_out = '0;
    tick; tick;

    // Reset state
    chk("reset_ctl", {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, d_wready,
                      mem_enable, mem_rw, mem_access_size}, 64'd0);
    chk("reset_addr", mem_address, 64'd0);
    chk("reset_wdata", mem_data_in, 64'd0);
    chk("reset_rdata", {i_rdata, d_rdata}, 64'd0);
    reset_n = 1'b1;

    // Single fetch read; low address bits must be forced to zero
    i_req = 1'b1; i_addr = 32'h8002_0001; i_size = 2'b00;
    tick;
    chk("t1_gnt", {i_gnt, d_gnt, mem_enable, mem_rw}, 64'b1011);
    chk("t1_addr", mem_address, 64'h8002_0000);
    chk("t1_size", mem_access_size, 64'd0);
    chk("t1_wdata_blocked", mem_data_in, 64'd0);
    chk("t1_no_rvalid", i_rvalid, 64'd0);
    tick;
    chk("t1_done", {i_rvalid, i_done, i_gnt, mem_enable}, 64'b1110);
    chk("t1_rdata", i_rdata, 64'h27BD_FFE8);
    i_req = 1'b0;
    tick;
    chk("t1_idle", {i_gnt, i_done, i_rvalid}, 64'd0);
    chk("t1_rdata_zero", i_rdata, 64'd0);

    // D 4-beat write
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h8002_0010; d_size = 2'b01; d_wdata = 32'd1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("t2_ctl", {d_gnt, i_gnt, mem_enable, mem_rw, d_wready}, 64'b10101);
      chk("t2_addr", mem_address, 64'(32'h8002_0010 + 32'(4 * k)));
      chk("t2_wdata", mem_data_in, 64'(k + 1));
      chk("t2_size", mem_access_size, 64'd1);
      d_wdata = 32'(k + 2);
      tick;
    end
    chk("t2_done", {d_done, d_gnt, mem_enable, d_wready, d_rvalid}, 64'b11000);
    d_req = 1'b0; d_wdata = 32'hDEAD_BEEF;
    tick;
    chk("t2_idle", {d_gnt, d_done}, 64'd0);

    // Both requesting from reset: D, I, D, I (fixed priority: D every time)
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_0200; i_size = 2'b00;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0000_0100; d_size = 2'b00;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!(i_gnt || d_gnt) && w < 8) begin tick; w++; end
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_d = 1'b1;
`else
      exp_d = (g % 2 == 0);
`endif
      chk("t3_winner", {i_gnt, d_gnt}, exp_d ? 64'b01 : 64'b10);
      chk("t3_addr", mem_address, exp_d ? 64'h100 : 64'h200);
      w = 0;
      while (!(i_done || d_done) && w < 4) begin tick; w++; end
      chk("t3_done", {i_done, d_done}, exp_d ? 64'b01 : 64'b10);
      tick;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick;

    // 8-beat fetch with a 2-cycle stall on the third beat
    i_req = 1'b1; i_addr = 32'h0000_1000; i_size = 2'b10;
    nrv = 0;
    tick;
    for (int c = 1; c <= 10; c++) begin
      b = (c <= 3) ? c - 1 : ((c <= 5) ? 2 : c - 3);
      chk("t4_addr", mem_address, 64'(32'h1000 + 32'(4 * b)));
      chk("t4_gnt", {i_gnt, mem_enable}, 64'b11);
      if (i_rvalid) begin
        ea = ~(32'h1000 + 32'(4 * nrv));
        chk("t4_rdata", i_rdata, 64'(ea));
        nrv++;
      end
      mem_busy = (c == 3 || c == 4);
      tick;
    end
    chk("t4_done", {i_done, mem_enable}, 64'b10);
    if (i_rvalid) begin
      ea = ~(32'h1000 + 32'(4 * nrv));
      chk("t4_rdata_last", i_rdata, 64'(ea));
      nrv++;
    end
    chk("t4_beats", 64'(nrv), 64'd8);
    i_req = 1'b0;
    tick;

    // Reset during beat 2 of a 16-beat D read
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0000_2000; d_size = 2'b11;
    tick;
    chk("t5_addr0", mem_address, 64'h2000);
    tick;
    chk("t5_beat2", {d_gnt, mem_enable}, 64'b11);
    chk("t5_addr1", mem_address, 64'h2004);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ctl", {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, d_wready,
                       mem_enable, mem_rw, mem_access_size}, 64'd0);
    chk("t5_rst_data", {mem_address, d_rdata}, 64'd0);
    d_req = 1'b0;
    tick; tick;
    chk("t5_no_done", d_done, 64'd0);
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h0000_3000; i_size = 2'b00;
    tick;
    chk("t5_new_gnt", {i_gnt, d_gnt, mem_enable}, 64'b101);
    chk("t5_new_addr", mem_address, 64'h3000);
    tick;
    chk("t5_new_done", {i_done, d_done}, 64'b10);
    i_req = 1'b0;
    tick;

    // 16-beat read wrapping through address zero
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'hFFFF_FFF8; d_size = 2'b11;
    nrv = 0;
    tick;
    for (int k = 0; k < 16; k++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("t6_addr", mem_address, 64'(ea));
      chk("t6_ctl", {d_gnt, mem_enable, mem_rw, i_rvalid}, 64'b1110);
      if (d_rvalid) nrv++;
      tick;
    end
    chk("t6_done", {d_done, mem_enable}, 64'b10);
    if (d_rvalid) nrv++;
    chk("t6_beats", 64'(nrv), 64'd16);
    d_req = 1'b0;
    tick;
    chk("t6_idle", {d_gnt, i_gnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
